// File: rtl/intt_pkg.sv
// Shared definitions for the inverse-NTT SDF stage: FSM encodings, modular add/sub, latency.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 32
`endif

package intt_pkg;

   localparam int unsigned DataW   = `DATA_SIZE_ARB;
   localparam int unsigned MaxW    = 64;
   localparam int unsigned MultLat = 12;
   localparam int unsigned L       = MultLat + 1;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StFill  = 2'd1;
   localparam logic [1:0] StBfly  = 2'd2;
   localparam logic [1:0] StDrain = 2'd3;

   // Operands are zero-extended to MaxW, so any W <= MaxW is handled by truncating the result.
   function automatic logic [MaxW-1:0] mod_add(input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                                               input logic [MaxW-1:0] q);
      logic [MaxW:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s >= {1'b0, q}) s = s - {1'b0, q};
      return s[MaxW-1:0];
   endfunction

   function automatic logic [MaxW-1:0] mod_sub(input logic [MaxW-1:0] a, input logic [MaxW-1:0] b,
                                               input logic [MaxW-1:0] q);
      logic [MaxW:0] d;
      d = {1'b0, a} - {1'b0, b};
      if (d[MaxW]) d = d + {1'b0, q};
      return d[MaxW-1:0];
   endfunction

endpackage

// File: rtl/ModMult.sv
// Pipelined modular multiplier: p = (a*b) mod q, LAT cycles after a/b are presented.
module ModMult #(
   parameter int unsigned W   = 32,
   parameter int unsigned LAT = 12
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] q,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] p
);

   logic [2*W-1:0] full;
   logic [W-1:0]   res;
   logic [W-1:0]   pipe_q [LAT];
   logic [W-1:0]   pipe_d [LAT];

   assign full = {{W{1'b0}}, a} * {{W{1'b0}}, b};
   assign res  = (q == '0) ? '0 : W'(full % {{W{1'b0}}, q});

   always_comb begin
      pipe_d    = pipe_q;
      pipe_d[0] = res;
      for (int i = 1; i < int'(LAT); i++) pipe_d[i] = pipe_q[i-1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) pipe_q <= '{default: '0};
      else        pipe_q <= pipe_d;
   end

   assign p = pipe_q[LAT-1];

endmodule

// File: rtl/intt_sdf_delay.sv
// Enable-gated D-deep shift register; entry D-1 is the oldest sample.
module intt_sdf_delay #(
   parameter int unsigned W = 32,
   parameter int unsigned D = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         en,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] mem_q [D];
   logic [W-1:0] mem_d [D];

   always_comb begin
      mem_d = mem_q;
      if (en) begin
         mem_d[0] = din;
         for (int i = 1; i < int'(D); i++) mem_d[i] = mem_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) mem_q <= '{default: '0};
      else        mem_q <= mem_d;
   end

   assign dout = mem_q[D-1];

endmodule

// File: rtl/intt_sdf_pe.sv
// Inverse-NTT radix-2 SDF stage: Gentleman-Sande butterfly, twiddle applied to the difference.
module intt_sdf_pe
   import intt_pkg::*;
#(
   parameter int unsigned W        = DataW,
   parameter int unsigned D        = 8,
   parameter int unsigned MULT_LAT = MultLat,
   localparam int unsigned CW      = (D > 1) ? $clog2(D) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [W-1:0]  q,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [W-1:0]  in_data,
   input  logic [W-1:0]  twiddle_i,
   output logic [CW-1:0] tw_addr,
   output logic          out_valid,
   output logic [W-1:0]  out_data
);

   localparam logic [CW-1:0] CntMax = CW'(D - 1);

   logic [1:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          pend_q, pend_d;
   logic          lv_q, lv_d, lsel_q, lsel_d;
   logic [W-1:0]  lsum_q, lsum_d, la_q, la_d, lb_q, lb_d;
   logic [W-1:0]  head, push, sum, diff, prod;
   logic          drain_now, accept, step, last;

   // The cycle after a frame's last BFLY sample drains unless the next frame starts right away.
   assign last      = (cnt_q == CntMax);
   assign drain_now = (state_q == StDrain) ||
                      (state_q == StFill && pend_q && cnt_q == '0 && !in_valid);
   assign in_ready  = !drain_now;
   assign accept    = in_valid && in_ready;
   assign step      = accept || drain_now;
   assign sum       = W'(mod_add(MaxW'(head), MaxW'(in_data), MaxW'(q)));
   assign diff      = W'(mod_sub(MaxW'(head), MaxW'(in_data), MaxW'(q)));
   assign push      = (state_q == StBfly) ? diff : (drain_now ? '0 : in_data);
   assign tw_addr   = (state_q == StFill || state_q == StDrain) ? cnt_q : '0;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      pend_d  = pend_q;
      lv_d    = 1'b0;
      lsel_d  = 1'b0;
      lsum_d  = '0;
      la_d    = '0;
      lb_d    = '0;
      unique case (state_q)
         StIdle, StFill: begin
            if (step && pend_q) begin
               lv_d   = 1'b1;
               lsel_d = 1'b1;
               la_d   = head;
               lb_d   = twiddle_i;
            end
            if (step) begin
               if (!last) begin
                  state_d = drain_now ? StDrain : StFill;
                  cnt_d   = cnt_q + 1'b1;
               end else begin
                  state_d = drain_now ? StIdle : StBfly;
                  cnt_d   = '0;
                  pend_d  = 1'b0;
               end
            end
         end
         StBfly: begin
            if (accept) begin
               lv_d   = 1'b1;
               lsum_d = sum;
               if (last) begin
                  state_d = StFill;
                  cnt_d   = '0;
                  pend_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StDrain: begin
            lv_d   = 1'b1;
            lsel_d = 1'b1;
            la_d   = head;
            lb_d   = twiddle_i;
            if (last) begin
               state_d = StIdle;
               cnt_d   = '0;
               pend_d  = 1'b0;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         pend_q  <= 1'b0;
         lv_q    <= 1'b0;
         lsel_q  <= 1'b0;
         lsum_q  <= '0;
         la_q    <= '0;
         lb_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
         lv_q    <= lv_d;
         lsel_q  <= lsel_d;
         lsum_q  <= lsum_d;
         la_q    <= la_d;
         lb_q    <= lb_d;
      end
   end

   intt_sdf_delay #(.W(W), .D(D)) u_delay (
      .clk  (clk),
      .reset(reset),
      .en   (step),
      .din  (push),
      .dout (head)
   );

   ModMult #(.W(W), .LAT(MULT_LAT)) u_mult (
      .clk  (clk),
      .reset(reset),
      .q    (q),
      .a    (la_q),
      .b    (lb_q),
      .p    (prod)
   );

   // Sum, valid and select ride alongside the multiplier so both result kinds share one latency.
   logic [MULT_LAT-1:0] v_pipe_q, v_pipe_d, sel_pipe_q, sel_pipe_d;
   logic [W-1:0]        sum_pipe_q [MULT_LAT];
   logic [W-1:0]        sum_pipe_d [MULT_LAT];

   always_comb begin
      v_pipe_d      = '0;
      sel_pipe_d    = '0;
      sum_pipe_d    = sum_pipe_q;
      v_pipe_d[0]   = lv_q;
      sel_pipe_d[0] = lsel_q;
      sum_pipe_d[0] = lsum_q;
      for (int i = 1; i < int'(MULT_LAT); i++) begin
         v_pipe_d[i]   = v_pipe_q[i-1];
         sel_pipe_d[i] = sel_pipe_q[i-1];
         sum_pipe_d[i] = sum_pipe_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         v_pipe_q   <= '0;
         sel_pipe_q <= '0;
         sum_pipe_q <= '{default: '0};
      end else begin
         v_pipe_q   <= v_pipe_d;
         sel_pipe_q <= sel_pipe_d;
         sum_pipe_q <= sum_pipe_d;
      end
   end

   assign out_valid = v_pipe_q[MULT_LAT-1];
   assign out_data  = !out_valid ? '0 :
                      (sel_pipe_q[MULT_LAT-1] ? prod : sum_pipe_q[MULT_LAT-1]);

endmodule

// File: tb/tb_intt_sdf_pe.sv
// Scoreboard bench for intt_sdf_pe: directed frames at q=17 on a D=2 and a D=1 instance.
module tb_intt_sdf_pe;

   localparam int unsigned W   = 32;
   localparam int unsigned ML  = 12;
   localparam int unsigned LAT = ML + 1;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic [W-1:0] q = 32'd17;

   logic         iv2 = 1'b0, ir2, ov2;
   logic [W-1:0] id2 = '0, tw2, od2;
   logic [0:0]   ta2;
   logic         iv1 = 1'b0, ir1, ov1;
   logic [W-1:0] id1 = '0, tw1, od1;
   logic [0:0]   ta1;

   // Inverse twiddle ROMs: D=2 uses w0=1, w1=4; D=1 uses w0=1.
   assign tw2 = (ta2 == 1'b0) ? 32'd1 : 32'd4;
   assign tw1 = 32'd1;

   intt_sdf_pe #(.W(W), .D(2), .MULT_LAT(ML)) dut2 (
      .clk(clk), .reset(reset), .q(q), .in_valid(iv2), .in_ready(ir2), .in_data(id2),
      .twiddle_i(tw2), .tw_addr(ta2), .out_valid(ov2), .out_data(od2)
   );

   intt_sdf_pe #(.W(W), .D(1), .MULT_LAT(ML)) dut1 (
      .clk(clk), .reset(reset), .q(q), .in_valid(iv1), .in_ready(ir1), .in_data(id1),
      .twiddle_i(tw1), .tw_addr(ta1), .out_valid(ov1), .out_data(od1)
   );

   always #5 clk = ~clk;

   int n_vec = 0, n_err = 0, cyc = 0;
   logic [W-1:0] exp2_q[$], exp1_q[$];
   int first_ov2 = -1, run2 = 0, max_run2 = 0, outs2 = 0;
   int acc_cyc2 = 0, stalls2 = 0;
   logic rdy2_s;
   logic [0:0] ta2_s;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (reset && ov2) begin
         outs2++;
         if (first_ov2 < 0) first_ov2 = cyc;
         run2++;
         if (run2 > max_run2) max_run2 = run2;
         if (exp2_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut2_unexpected: got out_data %0d, expected no output", od2);
         end else check("dut2_out", od2, exp2_q.pop_front());
      end else run2 = 0;
   end

   always @(negedge clk) begin
      if (reset && ov1) begin
         if (exp1_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL dut1_unexpected: got out_data %0d, expected no output", od1);
         end else check("dut1_out", od1, exp1_q.pop_front());
      end
   end

   // One cycle on dut2; starts and ends #1 after a rising edge.
   task automatic cyc2(input logic v, input logic [W-1:0] x, input int etw, output logic acc);
      iv2 = v;
      id2 = x;
      @(negedge clk);
      acc    = v && ir2;
      rdy2_s = ir2;
      ta2_s  = ta2;
      if (acc) acc_cyc2 = cyc;
      if (v && !ir2) stalls2++;
      if (acc && etw >= 0) check("tw_addr_fill", ta2, etw[0:0]);
      @(posedge clk);
      #1;
      iv2 = 1'b0;
   endtask

   task automatic send2(input logic [W-1:0] x, input int etw);
      logic acc;
      int   tries;
      tries = 0;
      do begin
         cyc2(1'b1, x, etw, acc);
         tries++;
      end while (!acc && tries < 50);
      if (!acc) begin
         n_vec++;
         n_err++;
         $display("FAIL dut2_accept_timeout: got no accept, expected accept of %0d", x);
      end
   endtask

   task automatic idle2(input int n);
      logic acc;
      for (int i = 0; i < n; i++) cyc2(1'b0, '0, -1, acc);
   endtask

   task automatic send1(input logic [W-1:0] x);
      int tries;
      tries = 0;
      iv1 = 1'b1;
      id1 = x;
      @(negedge clk);
      while (!ir1 && tries < 50) begin
         @(negedge clk);
         tries++;
      end
      if (!ir1) begin
         n_vec++;
         n_err++;
         $display("FAIL dut1_accept_timeout: got no accept, expected accept of %0d", x);
      end
      @(posedge clk);
      #1;
      iv1 = 1'b0;
   endtask

   task automatic wait_empty2(input string name);
      int n;
      n = 0;
      while (exp2_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, exp2_q.size(), 0);
      exp2_q.delete();
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_empty1(input string name);
      int n;
      n = 0;
      while (exp1_q.size() != 0 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check(name, exp1_q.size(), 0);
      exp1_q.delete();
      repeat (4) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      int c3;
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int c3;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", ir2, 1);
      check("rst_out_valid", ov2, 0);
      check("rst_out_data", od2, 0);
      check("rst_tw_addr", ta2, 0);
      check("rst_d1_tw_addr", ta1, 0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Single frame then idle: sums 4,6 then products 15*1, 15*4 mod 17.
      exp2_q.push_back(4); exp2_q.push_back(6); exp2_q.push_back(15); exp2_q.push_back(9);
      first_ov2 = -1;
      outs2 = 0;
      send2(1, -1);
      send2(2, -1);
      send2(3, -1);
      c3 = acc_cyc2;
      send2(4, -1);
      idle2(1);
      check("drain_ready0", rdy2_s, 0);
      check("drain_tw0", ta2_s, 0);
      idle2(1);
      check("drain_ready1", rdy2_s, 0);
      check("drain_tw1", ta2_s, 1);
      idle2(1);
      check("ready_after_drain", rdy2_s, 1);
      wait_empty2("frame1_drained");
      check("first_latency", 64'(first_ov2 - c3), 64'(LAT));
      check("frame1_count", outs2, 4);

      // D=1 wrap cases, back to back: (16,16) -> 15 / 0, (0,16) -> 16 / 1.
      exp1_q.push_back(15); exp1_q.push_back(0); exp1_q.push_back(16); exp1_q.push_back(1);
      send1(16);
      send1(16);
      send1(0);
      send1(16);
      wait_empty1("d1_drained");

      // Two back-to-back frames.
      exp2_q.push_back(4);  exp2_q.push_back(6);  exp2_q.push_back(15); exp2_q.push_back(9);
      exp2_q.push_back(12); exp2_q.push_back(14); exp2_q.push_back(15); exp2_q.push_back(9);
      max_run2 = 0;
      stalls2 = 0;
      send2(1, -1); send2(2, -1); send2(3, -1); send2(4, -1);
      send2(5, 0);  send2(6, 1);  send2(7, -1); send2(8, -1);
      idle2(2);
      wait_empty2("b2b_drained");
      check("b2b_contiguous", max_run2, 8);
      check("b2b_stalls", stalls2, 0);

      // Same two frames with random idle gaps.
      exp2_q.push_back(4);  exp2_q.push_back(6);  exp2_q.push_back(15); exp2_q.push_back(9);
      exp2_q.push_back(12); exp2_q.push_back(14); exp2_q.push_back(15); exp2_q.push_back(9);
      for (int i = 1; i <= 8; i++) begin
         idle2(int'($urandom_range(0, 3)));
         send2(W'(i), (i == 5) ? 0 : ((i == 6) ? 1 : -1));
      end
      idle2(2);
      wait_empty2("gaps_drained");

      // Reset during BFLY discards everything in flight.
      send2(1, -1);
      send2(2, -1);
      send2(3, -1);
      reset = 1'b0;
      @(negedge clk);
      check("rst_mid_out_valid", ov2, 0);
      check("rst_mid_in_ready", ir2, 1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      outs2 = 0;
      idle2(LAT + 4);
      check("post_rst_quiet", outs2, 0);
      exp2_q.push_back(4); exp2_q.push_back(6); exp2_q.push_back(15); exp2_q.push_back(9);
      send2(1, -1); send2(2, -1); send2(3, -1); send2(4, -1);
      idle2(2);
      wait_empty2("post_rst_drained");
      check("post_rst_count", outs2, 4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
